alu_share_arb: RTL and testbench



---
 rtl/alu_share_arb_pkg.sv | 38 +++
 rtl/alu_share_arb_alu.sv | 52 +++++
 rtl/alu_share_arb.sv | 160 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arb_pkg
// Shared constants for the ALU and the two-port ALU arbiter:
//   - ALU operand width and opcode width
//   - ALUOp opcode encoding (ALU_NOP .. ALU_LUI)
//   - requester count and the round-robin starting pointer
//   - aluReq_t, one ALU operation (operands plus opcode) as a packed bundle
// No ports; imported with "import alu_share_arb_pkg::*;".
// -----------------------------------------------------------------------------
package alu_share_arb_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 4;

  localparam logic [ALU_OPW-1:0] ALU_NOP  = 4'h0;
  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'h1;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'h2;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'h3;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'h4;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'h5;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'h6;
  localparam logic [ALU_OPW-1:0] ALU_NOR  = 4'h7;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'h8;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'h9;
  localparam logic [ALU_OPW-1:0] ALU_LUI  = 4'hA;

  // Two requesters share the ALU. The pointer starts at requester 1 so that
  // requester 0 wins the first tie after reset.
  localparam int   NUM_REQ  = 2;
  localparam logic RR_START = 1'b1;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [ALU_OPW-1:0]   op;
  } aluReq_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU used by the multi-cycle controller.
// Ports:
//   i_a      operand A (also the shift amount for SLL/SRL)
//   i_b      operand B (the value shifted by SLL/SRL/LUI)
//   i_aluOp  ALUOp opcode
//   o_c      result
//   o_zero   high when the result is zero
// Unknown opcodes (and NOP) pass operand A through unchanged.
// -----------------------------------------------------------------------------
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] i_a,
  input  logic [ALU_WIDTH-1:0] i_b,
  input  logic [ALU_OPW-1:0]   i_aluOp,
  output logic [ALU_WIDTH-1:0] o_c,
  output logic                 o_zero
);

  logic [ALU_WIDTH-1:0] w_result;
  logic                 w_slt;
  logic                 w_sltu;

  assign w_slt  = $signed(i_a) < $signed(i_b);
  assign w_sltu = i_a < i_b;

  // Opcode decode. The shift ops move B by the low five bits of A, which
  // matches how the controller feeds shamt through the A operand.
  always_comb begin
    w_result = i_a;
    case (i_aluOp)
      ALU_NOP:  w_result = i_a;
      ALU_ADD:  w_result = i_a + i_b;
      ALU_SUB:  w_result = i_a - i_b;
      ALU_AND:  w_result = i_a & i_b;
      ALU_OR:   w_result = i_a | i_b;
      ALU_SLT:  w_result = {{(ALU_WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU: w_result = {{(ALU_WIDTH-1){1'b0}}, w_sltu};
      ALU_NOR:  w_result = ~(i_a | i_b);
      ALU_SLL:  w_result = i_b << i_a[4:0];
      ALU_SRL:  w_result = i_b >> i_a[4:0];
      ALU_LUI:  w_result = {i_b[15:0], 16'h0000};
      default:  w_result = i_a;
    endcase
  end

  assign o_c    = w_result;
  assign o_zero = (w_result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Shares one combinational ALU between two requesters with round-robin
// arbitration. Each requester has a valid/ready operation port and a
// one-entry registered response slot with its own valid/ready handshake.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   reqN_valid / reqN_ready      operation handshake for requester N
//   reqN_a, reqN_b, reqN_op      operands and ALU opcode
//   rspN_valid / rspN_ready      response slot handshake for requester N
//   rspN_c, rspN_zero            captured ALU result and zero flag
//   last_grant                   index of the most recent grant (debug)
// -----------------------------------------------------------------------------
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rstn,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_zero,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_zero,

  output logic             last_grant
);

  if (WIDTH != ALU_WIDTH) begin : g_badWidth
    $error("alu_share_arb: WIDTH must be 32 to match the ALU");
  end
  if (OPW != ALU_OPW) begin : g_badOpw
    $error("alu_share_arb: OPW must match the ALUOp encoding width");
  end
  if (NUM_REQ != 2) begin : g_badReqCount
    $error("alu_share_arb: arbiter is built for exactly two requesters");
  end

  logic             r_rsp0Valid;
  logic [WIDTH-1:0] r_rsp0C;
  logic             r_rsp0Zero;
  logic             r_rsp1Valid;
  logic [WIDTH-1:0] r_rsp1C;
  logic             r_rsp1Zero;
  logic             r_lastGrant;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  aluReq_t          w_req0;
  aluReq_t          w_req1;
  aluReq_t          w_aluReq;
  logic [WIDTH-1:0] w_aluC;
  logic             w_aluZero;

  // A requester is eligible when it has an operation and its slot is either
  // empty or being drained this very cycle. Gating with rstn keeps both ready
  // outputs low during reset so no handshake can complete in that cycle.
  assign w_elig0 = rstn & req0_valid & (~r_rsp0Valid | rsp0_ready);
  assign w_elig1 = rstn & req1_valid & (~r_rsp1Valid | rsp1_ready);

  // On a tie the requester that did not win last time is granted; otherwise
  // the lone eligible requester wins. At most one grant is ever high.
  assign w_grant0 = w_elig0 & (~w_elig1 | r_lastGrant);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_lastGrant);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_req0 = {req0_a, req0_b, req0_op};
  assign w_req1 = {req1_a, req1_b, req1_op};

  // Operand mux into the shared ALU. With no grant the requester 0 operands
  // are presented; that result is never captured.
  always_comb begin
    w_aluReq = w_req0;
    if (w_grant1) begin
      w_aluReq = w_req1;
    end
  end

  alu u_alu (
    .i_a     (w_aluReq.a),
    .i_b     (w_aluReq.b),
    .i_aluOp (w_aluReq.op),
    .o_c     (w_aluC),
    .o_zero  (w_aluZero)
  );

  // Requester 0 response slot. A capture takes priority over a drain, so a
  // slot that is drained and refilled in the same cycle stays valid with the
  // new result. A plain drain only clears valid; the data keeps its value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp0Valid <= 1'b0;
      r_rsp0C     <= '0;
      r_rsp0Zero  <= 1'b0;
    end else if (w_grant0) begin
      r_rsp0Valid <= 1'b1;
      r_rsp0C     <= w_aluC;
      r_rsp0Zero  <= w_aluZero;
    end else if (rsp0_ready) begin
      r_rsp0Valid <= 1'b0;
    end
  end

  // Requester 1 response slot, same behaviour as slot 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp1Valid <= 1'b0;
      r_rsp1C     <= '0;
      r_rsp1Zero  <= 1'b0;
    end else if (w_grant1) begin
      r_rsp1Valid <= 1'b1;
      r_rsp1C     <= w_aluC;
      r_rsp1Zero  <= w_aluZero;
    end else if (rsp1_ready) begin
      r_rsp1Valid <= 1'b0;
    end
  end

  // Fairness pointer: remembers the last winner and only moves on a grant,
  // so idle cycles do not disturb who wins the next tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lastGrant <= RR_START;
    end else if (w_grant0) begin
      r_lastGrant <= 1'b0;
    end else if (w_grant1) begin
      r_lastGrant <= 1'b1;
    end
  end

  assign rsp0_valid = r_rsp0Valid;
  assign rsp0_c     = r_rsp0C;
  assign rsp0_zero  = r_rsp0Zero;
  assign rsp1_valid = r_rsp1Valid;
  assign rsp1_c     = r_rsp1C;
  assign rsp1_zero  = r_rsp1Zero;
  assign last_grant = r_lastGrant;

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
// Self-checking bench for alu_share_arb. Stimulus drives operations together
// with their expected results; a negedge monitor keeps its own model of slot
// occupancy and the fairness pointer, checks every ready/valid against it,
// queues the expected result on each grant and compares on each consume.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic [31:0] req0_a, req0_b, rsp0_c;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] req1_a, req1_b, rsp1_c;
  logic [3:0]  req1_op;
  logic        last_grant;

  logic [31:0] exp0, exp1;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        mValid0, mValid1, mLast;
  logic        hs0, hs1;
  int          testsRun;
  int          testsFailed;

  alu_share_arb #(.WIDTH(32), .OPW(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_c     (rsp0_c),
    .rsp0_zero  (rsp0_zero),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_c     (rsp1_c),
    .rsp1_zero  (rsp1_zero),
    .last_grant (last_grant)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent reference ALU used for the random stress section.
  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_NOR:  return ~(a | b);
      ALU_SLL:  return b << a[4:0];
      ALU_SRL:  return b >> a[4:0];
      ALU_LUI:  return b << 16;
      default:  return a;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] table_v [8];
    table_v[0] = 32'd0;          table_v[1] = 32'd1;
    table_v[2] = 32'd3;          table_v[3] = 32'hFFFFFFFF;
    table_v[4] = 32'h80000000;   table_v[5] = 32'h7FFFFFFF;
    table_v[6] = 32'h00001234;   table_v[7] = $urandom;
    return table_v[$urandom_range(0, 7)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] op0, input logic [31:0] e0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [3:0] op1, input logic [31:0] e1,
                               input logic r0, input logic r1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; exp0 = e0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; exp1 = e1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r0, input logic r1);
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, r0, r1);
  endtask

  // Monitor: checks grants and slot state against its own model, queues the
  // expected result on every grant and compares it when the slot is consumed.
  always @(negedge clk) begin
    logic e0, e1, g0, g1;
    logic [32:0] item;
    if (!rstn) begin
      checkOutput("req0_ready in reset", {31'd0, req0_ready}, 32'd0);
      checkOutput("req1_ready in reset", {31'd0, req1_ready}, 32'd0);
      mValid0 = 1'b0; mValid1 = 1'b0; mLast = 1'b1;
      hs0 = 1'b0; hs1 = 1'b0;
      q0.delete(); q1.delete();
    end else begin
      checkOutput("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, mValid0});
      checkOutput("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, mValid1});
      checkOutput("last_grant", {31'd0, last_grant}, {31'd0, mLast});
      e0 = req0_valid & (~mValid0 | rsp0_ready);
      e1 = req1_valid & (~mValid1 | rsp1_ready);
      g0 = e0 & (~e1 | mLast);
      g1 = e1 & (~e0 | ~mLast);
      checkOutput("req0_ready grant", {31'd0, req0_ready}, {31'd0, g0});
      checkOutput("req1_ready grant", {31'd0, req1_ready}, {31'd0, g1});
      if (mValid0 && rsp0_ready) begin
        if (q0.size() == 0) checkOutput("rsp0 queue underflow", 32'd0, 32'd1);
        else begin
          item = q0.pop_front();
          checkOutput("rsp0_c", rsp0_c, item[31:0]);
          checkOutput("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, item[32]});
        end
      end
      if (mValid1 && rsp1_ready) begin
        if (q1.size() == 0) checkOutput("rsp1 queue underflow", 32'd0, 32'd1);
        else begin
          item = q1.pop_front();
          checkOutput("rsp1_c", rsp1_c, item[31:0]);
          checkOutput("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, item[32]});
        end
      end
      if (g0) q0.push_back({exp0 == 32'd0, exp0});
      if (g1) q1.push_back({exp1 == 32'd0, exp1});
      mValid0 = g0 | (mValid0 & ~rsp0_ready);
      mValid1 = g1 | (mValid1 & ~rsp1_ready);
      if (g0) mLast = 1'b0;
      else if (g1) mLast = 1'b1;
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
    end
  end

  // Directed scenarios followed by random stress.
  initial begin
    testsRun = 0; testsFailed = 0;
    mValid0 = 1'b0; mValid1 = 1'b0; mLast = 1'b1; hs0 = 1'b0; hs1 = 1'b0;
    rstn = 1'b0;
    idle(1'b1, 1'b1);
    tick(); tick();
    checkOutput("reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("reset rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("reset rsp0_c", rsp0_c, 32'd0);
    checkOutput("reset rsp1_c", rsp1_c, 32'd0);
    checkOutput("reset rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
    checkOutput("reset last_grant", {31'd0, last_grant}, 32'd1);
    rstn = 1'b1;

    // Single port: ADD then SUB back to back.
    applyStimulus(1'b1, 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 1'b1);
    tick();
    checkOutput("t1 rsp0_c add", rsp0_c, 32'd8);
    checkOutput("t1 rsp0_zero add", {31'd0, rsp0_zero}, 32'd0);
    applyStimulus(1'b1, 32'd3, 32'd3, ALU_SUB, 32'd0, 1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 1'b1);
    tick();
    checkOutput("t1 rsp0_c sub", rsp0_c, 32'd0);
    checkOutput("t1 rsp0_zero sub", {31'd0, rsp0_zero}, 32'd1);
    idle(1'b1, 1'b1);
    tick();

    // Shifts, LUI and an undefined opcode through port 1.
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'd4, 32'h1, ALU_SLL, 32'h10, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'd4, 32'h80000000, ALU_SRL, 32'h08000000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'd0, 32'h1234, ALU_LUI, 32'h12340000, 1'b1, 1'b1);
    tick();
    checkOutput("t4 rsp1_c lui", rsp1_c, 32'h12340000);
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'hDEAD, 32'd7, 4'hF, 32'hDEAD, 1'b1, 1'b1);
    tick();
    checkOutput("t4 rsp1_c undefined op", rsp1_c, 32'hDEAD);
    idle(1'b1, 1'b1);
    tick();

    // Contention: grants alternate 0,1,0,1 starting with port 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'd7, 32'd2, ALU_SLT, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1, ALU_SLTU, 32'd0, 1'b1, 1'b1);
      tick();
    end
    checkOutput("t2 last_grant after 4", {31'd0, last_grant}, 32'd1);
    applyStimulus(1'b1, 32'd7, 32'd2, ALU_SLT, 32'd0, 1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'd1, ALU_SLT, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd1, ALU_SLTU, 32'd0, 1'b1, 1'b1);
      tick();
    end
    checkOutput("t2 rsp0_c signed slt", rsp0_c, 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1, ALU_SLTU, 32'd0, 1'b1, 1'b1);
    tick();
    idle(1'b1, 1'b1);
    tick();

    // Backpressure on port 1 while port 0 keeps being served.
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'd10, 32'd20, ALU_ADD, 32'd30, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b1, 32'd6, 32'd7, ALU_AND, 32'd6, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t3 rsp1_c held", rsp1_c, 32'd30);
    checkOutput("t3 last_grant port0", {31'd0, last_grant}, 32'd0);
    applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b1, 32'd6, 32'd7, ALU_AND, 32'd6, 1'b1, 1'b1);
    tick();
    checkOutput("t3 rsp1_valid no bubble", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("t3 rsp1_c replaced", rsp1_c, 32'd6);
    applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 1'b1);
    tick();
    idle(1'b1, 1'b1);
    tick();

    // Reset while slot 0 holds a result and port 1 is requesting.
    applyStimulus(1'b1, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b0, 1'b1);
    tick();
    rstn = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'd2, 32'd3, ALU_ADD, 32'd5, 1'b0, 1'b1);
    tick();
    rstn = 1'b1;
    checkOutput("t5 rsp0_valid cleared", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("t5 rsp1_valid cleared", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("t5 last_grant", {31'd0, last_grant}, 32'd1);
    applyStimulus(1'b1, 32'd1, 32'd2, ALU_OR, 32'd3, 1'b1, 32'd2, 32'd3, ALU_ADD, 32'd5, 1'b1, 1'b1);
    #2;
    checkOutput("t5 tie req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("t5 tie req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, ALU_NOP, 32'd0, 1'b1, 32'd2, 32'd3, ALU_ADD, 32'd5, 1'b1, 1'b1);
    tick();
    checkOutput("t5 rsp1_c after reset", rsp1_c, 32'd5);
    idle(1'b1, 1'b1);
    tick();

    // Random stress: requesters hold each operation until it is accepted.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [31:0] a, b;
      logic [3:0]  op;
      if (!req0_valid || hs0) begin
        a = pickOperand(); b = pickOperand(); op = 4'($urandom_range(0, 15));
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = a; req0_b = b; req0_op = op; exp0 = refAlu(a, b, op);
      end
      if (!req1_valid || hs1) begin
        a = pickOperand(); b = pickOperand(); op = 4'($urandom_range(0, 15));
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = a; req1_b = b; req1_op = op; exp1 = refAlu(a, b, op);
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    idle(1'b1, 1'b1);
    tick(); tick(); tick();
    checkOutput("final q0 empty", 32'(q0.size()), 32'd0);
    checkOutput("final q1 empty", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
